dram_cmd_sched: RTL and testbench
=================================

// Module: dram_cmd_sched
// PURPOSE
//  Single-outstanding DRAM request scheduler. Sits directly upstream of the bit-wide banked DRAM
//  device model. Accepts host read/write requests on a valid/ready handshake and splits the
//  flat address into bank/row/col. Tracks the open row per bank and enforces precharge/activate
//  waits. Drives the DRAM rw/bank/row/col/data pins and returns read data on a response strobe.
// PARAMETERS
//  NUM_OF_BANKS  8    banks in device; power of two
//  NUM_OF_ROWS   128  rows per bank; power of two
//  NUM_OF_COLS   8    columns per row; power of two
//  DATA_WIDTH    1    bits per column access
//  T_RP          2    precharge wait cycles (>=1)
//  T_RCD         2    activate-to-access wait cycles (>=1)
//  RD_LAT        1    cycles from read ACCESS cycle to data valid on dram_data (>=1)
// PORTS
//  clk           in   1     single clock, all logic on posedge
//  rst           in   1     asynchronous, active-high reset
//  req_valid     in   1     host request present
//  req_ready     out  1     scheduler can accept; high only in IDLE
//  req_we        in   1     1=write, 0=read
//  req_addr      in   AW    {bank,row,col}; AW=clog2(BANKS)+clog2(ROWS)+clog2(COLS), col in LSBs
//  req_wdata     in   DATA_WIDTH  write data
//  rsp_valid     out  1     one-cycle read-data strobe
//  rsp_rdata     out  DATA_WIDTH  read data, held until next read response
//  dram_rw       out  1     1=write, 0=read/idle (device writes on every cycle this is high)
//  dram_bank_id  out  clog2(BANKS)  bank select
//  dram_rowid    out  clog2(ROWS)   row select
//  dram_colid    out  clog2(COLS)   column select
//  dram_data     inout DATA_WIDTH   driven by scheduler only when dram_rw=1, else 'z
//  row_hit_cnt   out  16    saturating count of accepted requests that hit an open row
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; dram_rw=0; bank/row/col=0;
//   dram_data='z; open-row table all invalid; row_hit_cnt=0. Reset mid-operation aborts the
//   request silently, with no response.
//  dram_rw is 1 ONLY in the ACCESS cycle of a write; every other cycle it is 0 (idle reads are harmless).
//  FSM states: IDLE, PRE, ACT, ACCESS, RD_WAIT.
//   IDLE: on req_valid&req_ready, latch we/addr/wdata and look up the table using the incoming bank.
//     Hit (valid & row match): go to ACCESS and increment row_hit_cnt (saturating at 16'hFFFF).
//     Bank closed: go to ACT and load cnt=T_RCD-1.
//     Bank open, other row: go to PRE, load cnt=T_RP-1, and invalidate the entry.
//   PRE: lasts T_RP cycles. At cnt==0 go to ACT and load cnt=T_RCD-1.
//   ACT: lasts T_RCD cycles. At cnt==0 set entry={valid,row} and go to ACCESS.
//   ACCESS: lasts 1 cycle; dram_rw=we and dram_data=wdata if write.
//     Write: go to IDLE. Write requests get no response.
//     Read: go to RD_WAIT and load cnt=RD_LAT-1.
//   RD_WAIT: lasts RD_LAT cycles. At cnt==0, register dram_data into rsp_rdata, set rsp_valid=1
//     for the next cycle, and go to IDLE.
//  Bank/row/col outputs are registered from the latched address from PRE through RD_WAIT. In IDLE
//   they hold their last values.
//  Latency in cycles, accept at cycle 0:
//   Hit write: ACCESS at cycle 1; req_ready at cycle 2.
//   Hit read: rsp_valid at cycle 2+RD_LAT; IDLE is re-entered in the same cycle.
//   Closed bank: add T_RCD. Row conflict: add T_RP+T_RCD.
//  A request accepted in the same cycle rsp_valid is high is legal and proceeds normally.
//  Wait counter width: clog2(max(T_RP,T_RCD,RD_LAT)+1). The counter loads and decrements only in
//   waiting states, so there is no wrap-around.
// STRUCTURE
//  dram_pkg holds:
//   - the state enum (sched_state_t),
//   - functions bank_w/row_w/col_w/addr_w computing field widths from the geometry parameters,
//   - an addr-split helper.
//  Sub-module dram_open_row_table:
//   - per-bank {valid,row} registers with one lookup port (bank,row -> hit,open),
//   - set port and clear port (same-cycle set+clear on the same bank: set wins),
//   - async-reset-cleared.
// TESTING
//  1 Write addr{b3,r5,c2} d=1 to a closed bank -> ACT for 2 cycles, then one cycle with dram_rw=1,
//    bank=3/row=5/col=2/data=1; req_ready back at cycle 4.
//  2 Read addr{b3,r5,c2} right after test 1 -> hit, row_hit_cnt=1, rsp_valid at cycle 3,
//    rsp_rdata=1; dram_rw never 1.
//  3 Write b3/r5 then read b3/r9 -> PRE 2 + ACT 2 cycles before ACCESS; entry row becomes 9;
//    rsp_valid at cycle 7.
//  4 Back-to-back: req_valid held with 4 hit writes to cols 0..3 -> one accept every 2 cycles;
//    read-back of all 4 columns returns the written pattern 1,0,1,1.
//  5 Assert rst during PRE of a conflict request -> next cycle req_ready=1, dram_rw=0,
//    dram_data='z, no rsp_valid; the next access to the same bank takes the closed-bank (ACT) path.
//  6 Saturation: preload row_hit_cnt to 16'hFFFE via 2 further hits -> holds 16'hFFFF.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and geometry helpers for the DRAM command scheduler.
// Field widths are derived from bank/row/col counts; addresses are {bank,row,col}, col in the LSBs.
package dram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        ACT     = 3'd2,
        ACCESS  = 3'd3,
        RD_WAIT = 3'd4
    } sched_state_t;

    function automatic int bank_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int row_w(input int num_rows);
        return $clog2(num_rows);
    endfunction

    function automatic int col_w(input int num_cols);
        return $clog2(num_cols);
    endfunction

    function automatic int addr_w(input int num_banks, input int num_rows, input int num_cols);
        return bank_w(num_banks) + row_w(num_rows) + col_w(num_cols);
    endfunction

    // Extracts a w-bit field starting at bit lsb of a flat address.
    function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int w);
        return (addr >> lsb) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tracker: combinational lookup, registered set/clear, set wins over clear.
// Latency 0 on lookup, updates visible the cycle after set/clear; no backpressure.
module dram_open_row_table #(
    parameter int NB = 8,
    parameter int BW = 3,
    parameter int RW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] lk_bank,
    input  logic [RW-1:0] lk_row,
    output logic          lk_hit,
    output logic          lk_open,
    input  logic          set_vld,
    input  logic [BW-1:0] set_bank,
    input  logic [RW-1:0] set_row,
    input  logic          clr_vld,
    input  logic [BW-1:0] clr_bank
);

    logic [NB-1:0] vld_q;
    logic [RW-1:0] row_q [NB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int b = 0; b < NB; b++) row_q[b] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (set_vld && set_bank == BW'(b)) begin
                    vld_q[b] <= 1'b1;
                    row_q[b] <= set_row;
                end else if (clr_vld && clr_bank == BW'(b)) begin
                    vld_q[b] <= 1'b0;
                end
            end
        end
    end

    assign lk_open = vld_q[lk_bank];
    assign lk_hit  = lk_open && (row_q[lk_bank] == lk_row);

endmodule

// File: rtl/dram_cmd_sched.sv
// Single-outstanding DRAM scheduler: hit write 2 cycles, hit read rsp at 2+RD_LAT, +T_RCD closed, +T_RP+T_RCD conflict.
// req_ready is high only in IDLE; one request in flight, read data returned on a one-cycle rsp_valid strobe.
module dram_cmd_sched
    import dram_pkg::*;
#(
    parameter  int NUM_OF_BANKS = 8,
    parameter  int NUM_OF_ROWS  = 128,
    parameter  int NUM_OF_COLS  = 8,
    parameter  int DATA_WIDTH   = 1,
    parameter  int T_RP         = 2,
    parameter  int T_RCD        = 2,
    parameter  int RD_LAT       = 1,
    localparam int BW           = bank_w(NUM_OF_BANKS),
    localparam int RW           = row_w(NUM_OF_ROWS),
    localparam int CLW          = col_w(NUM_OF_COLS),
    localparam int AW           = addr_w(NUM_OF_BANKS, NUM_OF_ROWS, NUM_OF_COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  dram_rw,
    output logic [BW-1:0]         dram_bank_id,
    output logic [RW-1:0]         dram_rowid,
    output logic [CLW-1:0]        dram_colid,
    inout  wire  [DATA_WIDTH-1:0] dram_data,
    output logic [15:0]           row_hit_cnt
);

    localparam int TMAX = ((T_RP > T_RCD) ? T_RP : T_RCD) > RD_LAT ?
                          ((T_RP > T_RCD) ? T_RP : T_RCD) : RD_LAT;
    localparam int CW   = $clog2(TMAX + 1);

    sched_state_t          state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [15:0]           hit_cnt_q;

    logic                  accept;
    logic                  lk_hit, lk_open;
    logic                  tbl_set, tbl_clr, hit_inc, rsp_fire;
    logic [BW-1:0]         in_bank;
    logic [RW-1:0]         in_row;
    logic [CLW-1:0]        in_col;

    assign in_bank = BW'(addr_field(32'(req_addr), RW + CLW, BW));
    assign in_row  = RW'(addr_field(32'(req_addr), CLW, RW));
    assign in_col  = CLW'(addr_field(32'(req_addr), 0, CLW));

    assign req_ready   = (state_q == IDLE);
    assign accept      = req_valid && req_ready;
    assign dram_rw     = (state_q == ACCESS) && we_q;
    assign dram_data   = dram_rw ? wdata_q : 'z;
    assign row_hit_cnt = hit_cnt_q;

    dram_open_row_table #(
        .NB (NUM_OF_BANKS),
        .BW (BW),
        .RW (RW)
    ) u_tbl (
        .clk      (clk),
        .rst      (rst),
        .lk_bank  (in_bank),
        .lk_row   (in_row),
        .lk_hit   (lk_hit),
        .lk_open  (lk_open),
        .set_vld  (tbl_set),
        .set_bank (dram_bank_id),
        .set_row  (dram_rowid),
        .clr_vld  (tbl_clr),
        .clr_bank (in_bank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tbl_set  = 1'b0;
        tbl_clr  = 1'b0;
        hit_inc  = 1'b0;
        rsp_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lk_hit) begin
                        state_d = ACCESS;
                        hit_inc = 1'b1;
                    end else if (lk_open) begin
                        state_d = PRE;
                        cnt_d   = CW'(T_RP - 1);
                        tbl_clr = 1'b1;
                    end else begin
                        state_d = ACT;
                        cnt_d   = CW'(T_RCD - 1);
                    end
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    state_d = ACT;
                    cnt_d   = CW'(T_RCD - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                    tbl_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    rsp_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address pins are loaded at accept so they are already valid in the first working cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            wdata_q      <= '0;
            dram_bank_id <= '0;
            dram_rowid   <= '0;
            dram_colid   <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            hit_cnt_q    <= '0;
        end else begin
            rsp_valid <= rsp_fire;
            if (rsp_fire) rsp_rdata <= dram_data;
            if (accept) begin
                we_q         <= req_we;
                wdata_q      <= req_wdata;
                dram_bank_id <= in_bank;
                dram_rowid   <= in_row;
                dram_colid   <= in_col;
            end
            if (hit_inc && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Randomised scoreboard bench for dram_cmd_sched with a bit-wide banked memory device model.
// Expected write pin activity and read responses are queued at accept time and consumed by monitors.
module tb_dram_cmd_sched;

    localparam int T_RP   = 2;
    localparam int T_RCD  = 2;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [12:0] req_addr = '0;
    logic [0:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [0:0]  rsp_rdata;
    logic        dram_rw;
    logic [2:0]  dram_bank_id;
    logic [6:0]  dram_rowid;
    logic [2:0]  dram_colid;
    wire  [0:0]  dram_data;
    logic [15:0] row_hit_cnt;

    dram_cmd_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .dram_rw      (dram_rw),
        .dram_bank_id (dram_bank_id),
        .dram_rowid   (dram_rowid),
        .dram_colid   (dram_colid),
        .dram_data    (dram_data),
        .row_hit_cnt  (row_hit_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Device: writes on every dram_rw cycle, read data appears one cycle after the address.
    logic [0:0] mem_dev [8192] = '{default: 1'b0};
    logic [0:0] dev_q = 1'b0;
    always @(posedge clk) begin
        if (dram_rw) mem_dev[{dram_bank_id, dram_rowid, dram_colid}] <= dram_data;
        dev_q <= mem_dev[{dram_bank_id, dram_rowid, dram_colid}];
    end
    assign dram_data = dram_rw ? 1'bz : dev_q;

    typedef struct {int data; int cyc;} rd_exp_t;
    typedef struct {int bank; int row; int col; int data; int cyc;} wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t rd_e;
    wr_exp_t wr_e;

    // Reference model state
    bit model_open [8];
    int model_row  [8];
    bit model_mem  [8192];
    int exp_hits   = 0;
    int next_ready = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 8; b++) begin
            model_open[b] = 1'b0;
            model_row[b]  = 0;
        end
        exp_hits = 0;
    endtask

    task automatic issue(input bit we, input int bank, input int row, input int col,
                         input bit wd, input bit keep);
        int s, a, waitc, extra, idx;
        req_we    = we;
        req_addr  = 13'(bank * 1024 + row * 8 + col);
        req_wdata = wd;
        req_valid = 1'b1;
        s = cyc;
        waitc = 0;
        @(negedge clk);
        while (!req_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        a = cyc;
        check("accept_cycle", a, (s > next_ready) ? s : next_ready);
        if (model_open[bank] && model_row[bank] == row) begin
            extra = 0;
            if (exp_hits < 65535) exp_hits++;
        end else if (!model_open[bank]) begin
            extra = T_RCD;
        end else begin
            extra = T_RP + T_RCD;
        end
        model_open[bank] = 1'b1;
        model_row[bank]  = row;
        idx = bank * 1024 + row * 8 + col;
        if (we) begin
            model_mem[idx] = wd;
            wr_q.push_back('{bank, row, col, int'(wd), a + 1 + extra});
            next_ready = a + 2 + extra;
        end else begin
            rd_q.push_back('{int'(model_mem[idx]), a + 2 + RD_LAT + extra});
            next_ready = a + 2 + RD_LAT + extra;
        end
        @(posedge clk);
        #1;
        check("row_hit_cnt", int'(row_hit_cnt), exp_hits);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Read-response and write-pin monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    rd_e = rd_q.pop_front();
                    check("rsp_cycle", cyc, rd_e.cyc);
                    check("rsp_rdata", int'(rsp_rdata), rd_e.data);
                end
            end
            if (dram_rw) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_e = wr_q.pop_front();
                    check("wr_cycle", cyc, wr_e.cyc);
                    check("wr_bank", int'(dram_bank_id), wr_e.bank);
                    check("wr_row", int'(dram_rowid), wr_e.row);
                    check("wr_col", int'(dram_colid), wr_e.col);
                    check("wr_data", int'(dram_data), wr_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [4];
        pat = '{1, 0, 1, 1};
        model_reset();
        for (int i = 0; i < 8192; i++) model_mem[i] = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_rdata", int'(rsp_rdata), 0);
        check("rst_dram_rw", int'(dram_rw), 0);
        check("rst_bank", int'(dram_bank_id), 0);
        check("rst_row", int'(dram_rowid), 0);
        check("rst_col", int'(dram_colid), 0);
        check("rst_hit_cnt", int'(row_hit_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        next_ready = cyc;

        // Closed-bank write, then immediate hit read of the same location
        issue(1'b1, 3, 5, 2, 1'b1, 1'b1);
        issue(1'b0, 3, 5, 2, 1'b0, 1'b0);
        idle(3);

        // Row conflict: write r5 then read r9, then a hit on r9
        issue(1'b1, 3, 5, 1, 1'b0, 1'b0);
        issue(1'b0, 3, 9, 0, 1'b0, 1'b0);
        idle(5);

        // Back-to-back hit writes and read-back of the pattern
        for (int c = 0; c < 4; c++) issue(1'b1, 3, 9, c, pat[c][0], 1'b1);
        for (int c = 0; c < 4; c++) issue(1'b0, 3, 9, c, 1'b0, (c != 3));
        idle(5);

        // Reset while a conflict request sits in precharge
        issue(1'b0, 3, 1, 4, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        model_reset();
        @(negedge clk);
        check("abort_req_ready", int'(req_ready), 1);
        check("abort_dram_rw", int'(dram_rw), 0);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_hit_cnt", int'(row_hit_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        next_ready = cyc;
        issue(1'b0, 3, 1, 4, 1'b0, 1'b0);
        idle(4);

        // Counter saturation
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.hit_cnt_q;
        exp_hits = 16'hFFFE;
        issue(1'b0, 3, 1, 4, 1'b0, 1'b0);
        idle(4);
        issue(1'b0, 3, 1, 5, 1'b0, 1'b0);
        idle(4);

        // Randomised traffic over a small row set to mix hits, closed banks and conflicts
        for (int n = 0; n < 200; n++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 2),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)), keep);
            if (!keep) idle($urandom_range(0, 2));
        end
        req_valid = 1'b0;

        for (int i = 0; i < 60 && (rd_q.size() != 0 || wr_q.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        check("drain_rd_q", rd_q.size(), 0);
        check("drain_wr_q", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
